// File: rtl/uart_pkg.sv
// Shared UART constants and width helpers.
package uart_pkg;

   localparam int unsigned UART_DATA_W             = 8;
   localparam int unsigned RX_FIFO_DEPTH_DEFAULT   = 16;
   localparam int unsigned RX_FIFO_THRESH_DEFAULT  = 8;
   localparam int unsigned RX_FIFO_TIMEOUT_DEFAULT = 640;

   // Pointer/level width: index bits plus one wrap bit.
   localparam int unsigned RX_FIFO_PTR_W_DEFAULT   = $clog2(RX_FIFO_DEPTH_DEFAULT) + 1;
   // Idle counter width: must hold TIMEOUT_CYCLES itself.
   localparam int unsigned RX_FIFO_TMO_W_DEFAULT   = $clog2(RX_FIFO_TIMEOUT_DEFAULT + 1);

endpackage : uart_pkg

// File: rtl/fifo_mem.sv
// Byte storage for rx_fifo: one synchronous write port, one combinational read port, no reset.
module fifo_mem
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = RX_FIFO_DEPTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [UART_DATA_W-1:0]     wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [UART_DATA_W-1:0]     rdata
);

   logic [UART_DATA_W-1:0] mem [DEPTH];

   // Write the incoming byte at the write index.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Head-of-queue read, no latency.
   assign rdata = mem[raddr];

endmodule : fifo_mem

// File: rtl/rx_fifo.sv
// Receive byte FIFO between the UART receiver and the host: FWFT read side,
// fill level, threshold flag and character-timeout flag.
module rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH          = RX_FIFO_DEPTH_DEFAULT,
   parameter int unsigned THRESH         = RX_FIFO_THRESH_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = RX_FIFO_TIMEOUT_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [UART_DATA_W-1:0]   rx_data,
   input  logic                     rx_data_valid,
   output logic                     host_ready,
   output logic [UART_DATA_W-1:0]   rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     thresh_hit,
   output logic                     rx_timeout
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [PW-1:0]          wr_ptr_nxt;
   logic [PW-1:0]          rd_ptr_nxt;
   logic [PW-1:0]          level_nxt;
   logic [TW-1:0]          tmo_cnt;
   logic [TW-1:0]          tmo_cnt_nxt;
   logic                   thresh_nxt;
   logic                   tmo_nxt;
   logic                   empty;
   logic                   full;
   logic                   push;
   logic                   pop;
   logic [UART_DATA_W-1:0] mem_rdata;

   fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (rx_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (mem_rdata)
   );

   // Status and handshakes; host_ready is gated by rst_n so it drops the instant reset asserts.
   always_comb begin
      empty      = (wr_ptr == rd_ptr);
      full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
      host_ready = rst_n & rx_data_valid & ~full & ~flush;
      push       = rx_data_valid & host_ready;
      rd_valid   = ~empty;
      pop        = ~empty & rd_ready & ~flush;
      rd_data    = empty ? '0 : mem_rdata;
   end

   // Next pointers, level, idle counter and flags; flush overrides push and pop.
   always_comb begin
      wr_ptr_nxt  = wr_ptr;
      rd_ptr_nxt  = rd_ptr;
      level_nxt   = level;
      tmo_cnt_nxt = tmo_cnt;
      if (flush) begin
         wr_ptr_nxt  = '0;
         rd_ptr_nxt  = '0;
         level_nxt   = '0;
         tmo_cnt_nxt = '0;
      end else begin
         if (push) begin
            wr_ptr_nxt = wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr_nxt = rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            level_nxt = level + PW'(1);
         end else if (pop && !push) begin
            level_nxt = level - PW'(1);
         end
         if (push || pop) begin
            tmo_cnt_nxt = '0;
         end else if (level == '0) begin
            tmo_cnt_nxt = '0;
         end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
            tmo_cnt_nxt = tmo_cnt + TW'(1);
         end
      end
      thresh_nxt = (level_nxt >= PW'(THRESH));
      tmo_nxt    = !flush && !push && !pop &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES)) && (level != '0);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         tmo_cnt    <= '0;
         thresh_hit <= 1'b0;
         rx_timeout <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         level      <= level_nxt;
         tmo_cnt    <= tmo_cnt_nxt;
         thresh_hit <= thresh_nxt;
         rx_timeout <= tmo_nxt;
      end
   end

endmodule : rx_fifo

// File: tb/tb_rx_fifo.sv
// Bench for rx_fifo: directed stimulus, byte scoreboard checked by a separate pop monitor.
module tb_rx_fifo;

   logic       clk;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       host_ready;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic       flush;
   logic [4:0] level;
   logic       thresh_hit;
   logic       rx_timeout;

   int         errors;
   int         checks;
   logic [7:0] exp_q[$];
   logic       seen_tmo;

   rx_fifo #(
      .DEPTH          (16),
      .THRESH         (8),
      .TIMEOUT_CYCLES (640)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_data       (rx_data),
      .rx_data_valid (rx_data_valid),
      .host_ready    (host_ready),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .rd_ready      (rd_ready),
      .flush         (flush),
      .level         (level),
      .thresh_hit    (thresh_hit),
      .rx_timeout    (rx_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      rd_ready = 1'b1;
      for (int n = 0; n < 40 && rd_valid; n++) cyc();
      rd_ready = 1'b0;
      chk({name, "_rd_valid"}, 32'(rd_valid), 32'd0);
      chk({name, "_level"}, 32'(level), 32'd0);
   endtask

   // Monitor: every accepted pop must match the oldest expected byte.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rst_n && rd_valid && rd_ready && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected: got %02h required no pop", rd_data);
            end else begin
               b = exp_q.pop_front();
               if (rd_data !== b) begin
                  errors++;
                  $display("FAIL rd_data: got %02h required %02h", rd_data, b);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      errors        = 0;
      checks        = 0;
      rst_n         = 1'b0;
      rx_data       = 8'h00;
      rx_data_valid = 1'b1;
      rd_ready      = 1'b0;
      flush         = 1'b0;
      #12;
      // Reset state; host_ready held low even with a byte offered.
      chk("rst_host_ready", 32'(host_ready), 32'd0);
      chk("rst_rd_valid",   32'(rd_valid),   32'd0);
      chk("rst_level",      32'(level),      32'd0);
      chk("rst_thresh",     32'(thresh_hit), 32'd0);
      chk("rst_timeout",    32'(rx_timeout), 32'd0);
      chk("rst_rd_data",    32'(rd_data),    32'd0);
      rx_data_valid = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();

      // Fill 0x00..0x0F back-to-back.
      for (int i = 0; i < 16; i++) begin
         rx_data       = 8'(i);
         rx_data_valid = 1'b1;
         #1;
         chk("fill_host_ready", 32'(host_ready), 32'd1);
         exp_q.push_back(8'(i));
         cyc();
         if (i == 6) chk("thresh_at_7", 32'(thresh_hit), 32'd0);
         if (i == 7) chk("thresh_at_8", 32'(thresh_hit), 32'd1);
      end
      chk("full_level",      32'(level),      32'd16);
      chk("full_host_ready", 32'(host_ready), 32'd0);

      // Backpressure: byte held for 20 cycles while full.
      rx_data = 8'hA5;
      for (int i = 0; i < 20; i++) begin
         chk("bp_host_ready", 32'(host_ready), 32'd0);
         cyc();
      end
      chk("bp_level", 32'(level), 32'd16);
      rd_ready = 1'b1;
      cyc();
      rd_ready = 1'b0;
      #1;
      chk("bp_reready",     32'(host_ready), 32'd1);
      chk("bp_level_after", 32'(level),      32'd15);
      exp_q.push_back(8'hA5);
      cyc();
      rx_data_valid = 1'b0;
      chk("bp_level_full", 32'(level), 32'd16);
      drain("drain1");
      chk("drain_thresh", 32'(thresh_hit), 32'd0);

      // Simultaneous push/pop at level 1, across the index wrap.
      rx_data = 8'h30;
      rx_data_valid = 1'b1;
      exp_q.push_back(8'h30);
      cyc();
      rd_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rx_data = 8'(8'h31 + i);
         exp_q.push_back(8'(8'h31 + i));
         cyc();
         chk("pp1_level", 32'(level), 32'd1);
      end
      rx_data_valid = 1'b0;
      cyc();
      rd_ready = 1'b0;
      chk("pp1_end_level", 32'(level), 32'd0);

      // Simultaneous push/pop at level 15.
      rx_data_valid = 1'b1;
      for (int i = 0; i < 15; i++) begin
         rx_data = 8'(8'h40 + i);
         exp_q.push_back(8'(8'h40 + i));
         cyc();
      end
      chk("pp15_start", 32'(level), 32'd15);
      rd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rx_data = 8'(8'h50 + i);
         #1;
         chk("pp15_host_ready", 32'(host_ready), 32'd1);
         exp_q.push_back(8'(8'h50 + i));
         cyc();
         chk("pp15_level", 32'(level), 32'd15);
      end
      rx_data_valid = 1'b0;
      drain("drain2");

      // Timeout: one byte, then idle.
      rx_data = 8'h77;
      rx_data_valid = 1'b1;
      exp_q.push_back(8'h77);
      cyc();
      rx_data_valid = 1'b0;
      repeat (640) cyc();
      chk("tmo_640", 32'(rx_timeout), 32'd0);
      cyc();
      chk("tmo_641", 32'(rx_timeout), 32'd1);
      rd_ready = 1'b1;
      cyc();
      rd_ready = 1'b0;
      chk("tmo_clear", 32'(rx_timeout), 32'd0);
      chk("tmo_level", 32'(level), 32'd0);

      // Idle while empty must never time out.
      seen_tmo = 1'b0;
      repeat (2000) begin
         cyc();
         if (rx_timeout) seen_tmo = 1'b1;
      end
      chk("idle_empty_tmo", 32'(seen_tmo), 32'd0);

      // Flush at level 5 together with push and pop.
      rx_data_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rx_data = 8'(8'h60 + i);
         exp_q.push_back(8'(8'h60 + i));
         cyc();
      end
      chk("flush_pre_level", 32'(level), 32'd5);
      rx_data  = 8'h99;
      rd_ready = 1'b1;
      flush    = 1'b1;
      #1;
      chk("flush_host_ready", 32'(host_ready), 32'd0);
      cyc();
      exp_q.delete();
      flush         = 1'b0;
      rd_ready      = 1'b0;
      rx_data_valid = 1'b0;
      chk("flush_level",    32'(level),      32'd0);
      chk("flush_rd_valid", 32'(rd_valid),   32'd0);
      chk("flush_timeout",  32'(rx_timeout), 32'd0);

      // Async reset between edges mid-stream.
      rx_data_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rx_data = 8'(8'h11 + i);
         cyc();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_host_ready", 32'(host_ready), 32'd0);
      chk("arst_rd_valid",   32'(rd_valid),   32'd0);
      chk("arst_level",      32'(level),      32'd0);
      rx_data_valid = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      rx_data_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rx_data = 8'(8'h21 + i);
         exp_q.push_back(8'(8'h21 + i));
         cyc();
      end
      rx_data_valid = 1'b0;
      chk("post_rst_level", 32'(level), 32'd2);
      drain("drain3");
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_rx_fifo
